// File: rtl/ahb_apb_pkg.sv
// Shared state encoding and AHB bus encodings for the AHB-to-APB bridge family.
package ahb_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PEND   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR1   = 3'd5,
      ST_ERR2   = 3'd6
   } bridge_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   function automatic logic htrans_active(input logic [1:0] trans);
      logic act;
      case (trans)
         HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         default: act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Fixed-window APB slave decode: index field extraction, range flag and one-hot select.
module apb_slave_decode
   import ahb_apb_pkg::*;
#(
   parameter int HADDR_WIDTH = 32,
   parameter int PADDR_WIDTH = 16,
   parameter int SEL_BITS    = 4,
   parameter int PSLV_NUM    = 5
) (
   input  logic [HADDR_WIDTH-1:0] addr,
   output logic [SEL_BITS-1:0]    idx,
   output logic                   in_range,
   output logic [PSLV_NUM-1:0]    onehot
);

   localparam logic [SEL_BITS:0] SLV_COUNT = (SEL_BITS+1)'(PSLV_NUM);

   logic unused_s;

   assign idx      = addr[PADDR_WIDTH +: SEL_BITS];
   assign in_range = ({1'b0, idx} < SLV_COUNT);
   assign unused_s = ^addr;

   // One-hot select; indices beyond the slave count yield all zeros.
   always_comb begin
      onehot = {PSLV_NUM{1'b0}};
      for (int k = 0; k < PSLV_NUM; k++) begin
         onehot[k] = (idx == SEL_BITS'(k));
      end
   end

endmodule

// File: rtl/ahb2apb_bridge_pipe.sv
// AHB-Lite to APB bridge: registered capture, windowed slave decode, pclken-qualified
// APB phases, access timeout and a two-cycle AHB ERROR on slave error or timeout.
module ahb2apb_bridge_pipe
   import ahb_apb_pkg::*;
#(
   parameter int HADDR_WIDTH = 32,
   parameter int PADDR_WIDTH = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int PSLV_NUM    = 5,
   parameter int SEL_BITS    = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                           hclk,
   input  logic                           hresetn,
   input  logic                           hsel_i,
   input  logic [HADDR_WIDTH-1:0]         haddr,
   input  logic [1:0]                     htrans,
   input  logic                           hwrite,
   input  logic [2:0]                     hsize,
   input  logic [DATA_WIDTH-1:0]          hwdata,
   input  logic [DATA_WIDTH/8-1:0]        hwstrb,
   input  logic                           hready_i,
   output logic                           hready_o,
   output logic                           hresp_o,
   output logic [DATA_WIDTH-1:0]          hrdata_o,
   input  logic                           pclken,
   output logic [PADDR_WIDTH-1:0]         paddr,
   output logic [PSLV_NUM-1:0]            psel,
   output logic                           penable,
   output logic                           pwrite,
   output logic [DATA_WIDTH-1:0]          pwdata,
   output logic [DATA_WIDTH/8-1:0]        pstrb,
   input  logic [PSLV_NUM-1:0]            pready_i,
   input  logic [PSLV_NUM-1:0]            pslverr_i,
   input  logic [PSLV_NUM*DATA_WIDTH-1:0] prdata_i
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
   localparam bit TO_EN = (TIMEOUT_CYC != 0);

   bridge_state_t           state_r, state_nxt_s;
   logic [TO_W-1:0]         cnt_r;
   logic [PSLV_NUM-1:0]     sel_onehot_r;
   logic [2:0]              hsize_r;
   logic [SEL_BITS-1:0]     dec_idx_s;
   logic                    dec_in_range_s;
   logic [PSLV_NUM-1:0]     dec_onehot_s;
   logic                    accept_s, sel_ready_s, sel_err_s, timeout_s, unused_s;
   logic [DATA_WIDTH-1:0]   prdata_sel_s;

   apb_slave_decode #(
      .HADDR_WIDTH(HADDR_WIDTH),
      .PADDR_WIDTH(PADDR_WIDTH),
      .SEL_BITS   (SEL_BITS),
      .PSLV_NUM   (PSLV_NUM)
   ) u_decode (
      .addr    (haddr),
      .idx     (dec_idx_s),
      .in_range(dec_in_range_s),
      .onehot  (dec_onehot_s)
   );

   assign accept_s    = hsel_i & htrans_active(htrans) & hready_i & hready_o;
   assign sel_ready_s = |(pready_i & sel_onehot_r);
   assign sel_err_s   = |(pslverr_i & sel_onehot_r);
   assign timeout_s   = TO_EN && ((cnt_r + TO_W'(1'b1)) == TO_LIMIT);
   assign unused_s    = ^{hsize_r, dec_idx_s};

   // AHB response decoded only from the state register.
   always_comb begin
      hready_o = 1'b1;
      hresp_o  = HRESP_OKAY;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            hready_o = 1'b1;
            hresp_o  = HRESP_OKAY;
         end
         ST_PEND, ST_SETUP, ST_ACCESS: begin
            hready_o = 1'b0;
            hresp_o  = HRESP_OKAY;
         end
         ST_ERR1: begin
            hready_o = 1'b0;
            hresp_o  = HRESP_ERROR;
         end
         ST_ERR2: begin
            hready_o = 1'b1;
            hresp_o  = HRESP_ERROR;
         end
         default: begin
            hready_o = 1'b1;
            hresp_o  = HRESP_OKAY;
         end
      endcase
   end

   // Read-data mux over the slave currently being accessed.
   always_comb begin
      prdata_sel_s = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < PSLV_NUM; k++) begin
         prdata_sel_s = prdata_sel_s |
                        (prdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_onehot_r[k]}});
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (accept_s) begin
               state_nxt_s = dec_in_range_s ? ST_PEND : ST_ERR1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PEND: state_nxt_s = ST_SETUP;
         ST_SETUP: begin
            if (pclken) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_SETUP;
            end
         end
         ST_ACCESS: begin
            if (!pclken) begin
               state_nxt_s = ST_ACCESS;
            end else if (sel_ready_s) begin
               state_nxt_s = sel_err_s ? ST_ERR1 : ST_DONE;
            end else if (timeout_s) begin
               state_nxt_s = ST_ERR1;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         ST_ERR1: state_nxt_s = ST_ERR2;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and ACCESS timeout counter (cleared whenever outside ACCESS).
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_r <= ST_IDLE;
         cnt_r   <= {TO_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r != ST_ACCESS) begin
            cnt_r <= {TO_W{1'b0}};
         end else if (pclken && !sel_ready_s) begin
            cnt_r <= cnt_r + TO_W'(1'b1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Address/data capture and registered APB/AHB outputs.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         paddr        <= {PADDR_WIDTH{1'b0}};
         pwrite       <= 1'b0;
         pwdata       <= {DATA_WIDTH{1'b0}};
         pstrb        <= {STRB_W{1'b0}};
         psel         <= {PSLV_NUM{1'b0}};
         penable      <= 1'b0;
         hrdata_o     <= {DATA_WIDTH{1'b0}};
         sel_onehot_r <= {PSLV_NUM{1'b0}};
         hsize_r      <= 3'b000;
      end else begin
         if (accept_s) begin
            paddr        <= haddr[PADDR_WIDTH-1:0];
            pwrite       <= hwrite;
            sel_onehot_r <= dec_onehot_s;
            hsize_r      <= hsize;
         end
         // Write data is only valid in the AHB data phase, i.e. the PEND cycle.
         if (state_r == ST_PEND) begin
            if (pwrite) begin
               pwdata <= hwdata;
               pstrb  <= hwstrb;
            end else begin
               pstrb  <= {STRB_W{1'b0}};
            end
         end
         psel    <= ((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS)) ?
                    sel_onehot_r : {PSLV_NUM{1'b0}};
         penable <= (state_nxt_s == ST_ACCESS);
         if ((state_r == ST_ACCESS) && (state_nxt_s == ST_DONE) && !pwrite) begin
            hrdata_o <= prdata_sel_s;
         end
      end
   end

endmodule

// File: tb/tb_ahb2apb_bridge_pipe.sv
// Scoreboard bench for ahb2apb_bridge_pipe: directed transfers push expected AHB and APB
// behaviour into queues; independent monitors compare when the DUT presents it.
module tb_ahb2apb_bridge_pipe;
   import ahb_apb_pkg::*;

   localparam int NS = 5;
   localparam int DW = 32;

   typedef struct {
      logic        resp;
      logic [31:0] rdata;
      int          waits;
   } ahb_exp_t;

   typedef struct {
      logic [15:0] paddr;
      logic [4:0]  psel;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          nsetup;
      int          nacc;
   } apb_exp_t;

   logic            hclk = 1'b0;
   logic            hresetn, hsel_i, hwrite, hready_i, hready_o, hresp_o, pclken;
   logic [31:0]     haddr, hwdata, hrdata_o, pwdata;
   logic [1:0]      htrans;
   logic [2:0]      hsize;
   logic [3:0]      hwstrb, pstrb;
   logic [15:0]     paddr;
   logic [NS-1:0]   psel, pready_i, pslverr_i;
   logic            penable, pwrite;
   logic [NS*DW-1:0] prdata_i;

   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   bit  toggle_en = 1'b0;

   ahb2apb_bridge_pipe #(
      .HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(DW),
      .PSLV_NUM(NS), .SEL_BITS(4), .TIMEOUT_CYC(4)
   ) dut (
      .hclk(hclk), .hresetn(hresetn), .hsel_i(hsel_i), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready_i(hready_i),
      .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o), .pclken(pclken),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .pstrb(pstrb), .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
   );

   always #5 hclk = ~hclk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   task automatic step();
      @(posedge hclk);
      #1;
      if (toggle_en) pclken = ~pclken;
   endtask

   task automatic exp_ahb(input logic resp, input logic [31:0] rdata, input int waits);
      ahb_exp_t e;
      e.resp = resp; e.rdata = rdata; e.waits = waits;
      ahb_q.push_back(e);
   endtask

   task automatic exp_apb(input logic [15:0] pa, input logic [4:0] ps, input logic wr,
                          input logic [31:0] wd, input logic [3:0] st, input int ns, input int na);
      apb_exp_t a;
      a.paddr = pa; a.psel = ps; a.wr = wr; a.wdata = wd; a.strb = st; a.nsetup = ns; a.nacc = na;
      apb_q.push_back(a);
   endtask

   task automatic addr_phase(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [3:0] strb);
      hsel_i = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = 3'b010;
      step();
      hsel_i = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata; hwstrb = strb;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!hready_o && n < 40) begin
         step();
         n++;
      end
      chk("ahb_wait_bound", {31'd0, hready_o}, 32'd1);
   endtask

   // AHB monitor: counts wait states of each accepted transfer and checks its completion.
   initial begin
      ahb_exp_t e;
      bit dp_active;
      int waits;
      logic prev_hresp;
      dp_active = 1'b0; waits = 0; prev_hresp = 1'b0;
      forever begin
         @(negedge hclk);
         if (!hresetn) begin
            dp_active = 1'b0;
         end else begin
            if (dp_active) begin
               if (hready_o) begin
                  if (ahb_q.size() == 0) begin
                     chk("ahb_unexpected_done", 32'd1, 32'd0);
                  end else begin
                     e = ahb_q.pop_front();
                     chk("ahb_resp", {31'd0, hresp_o}, {31'd0, e.resp});
                     chk("ahb_rdata", hrdata_o, e.rdata);
                     chk("ahb_waits", waits, e.waits);
                     if (e.resp) chk("ahb_err_first_cycle", {31'd0, prev_hresp}, 32'd1);
                  end
                  dp_active = 1'b0;
               end else begin
                  waits++;
               end
            end
            if (hsel_i && htrans[1] && hready_i && hready_o) begin
               dp_active = 1'b1;
               waits = 0;
            end
         end
         prev_hresp = hresp_o;
      end
   end

   // APB monitor: checks address/control/data through SETUP and ACCESS and phase counts.
   initial begin
      apb_exp_t a;
      bit active, prev_setup;
      logic prev_pclken;
      int nsetup, nacc;
      active = 1'b0; prev_setup = 1'b0; prev_pclken = 1'b0; nsetup = 0; nacc = 0;
      forever begin
         @(negedge hclk);
         if (!hresetn) begin
            if (active) void'(apb_q.pop_front());
            active = 1'b0;
            prev_setup = 1'b0;
         end else if (psel != '0) begin
            if (apb_q.size() == 0) begin
               chk("apb_unexpected_psel", {27'd0, psel}, 32'd0);
            end else begin
               a = apb_q[0];
               if (!active) begin
                  active = 1'b1; nsetup = 0; nacc = 0;
               end
               chk("apb_paddr", {16'd0, paddr}, {16'd0, a.paddr});
               chk("apb_psel", {27'd0, psel}, {27'd0, a.psel});
               chk("apb_pwrite", {31'd0, pwrite}, {31'd0, a.wr});
               chk("apb_pstrb", {28'd0, pstrb}, {28'd0, a.strb});
               if (a.wr) chk("apb_pwdata", pwdata, a.wdata);
               if (penable) begin
                  nacc++;
                  if (prev_setup) chk("apb_setup_exit_pclken", {31'd0, prev_pclken}, 32'd1);
               end else begin
                  nsetup++;
               end
            end
            prev_setup = !penable;
         end else begin
            if (active) begin
               a = apb_q.pop_front();
               chk("apb_setup_cycles", nsetup, a.nsetup);
               chk("apb_access_cycles", nacc, a.nacc);
               active = 1'b0;
            end
            prev_setup = 1'b0;
         end
         prev_pclken = pclken;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      hresetn = 1'b0; hsel_i = 1'b0; haddr = 32'd0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      hsize = 3'b010; hwdata = 32'd0; hwstrb = 4'd0; hready_i = 1'b1; pclken = 1'b1;
      pready_i = 5'b11111; pslverr_i = 5'b00000;
      for (int k = 0; k < NS; k++) prdata_i[k*DW +: DW] = 32'hA5A5_0000 + 32'(k);
      repeat (3) step();

      // Reset values
      chk("rst_psel", {27'd0, psel}, 32'd0);
      chk("rst_penable", {31'd0, penable}, 32'd0);
      chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
      chk("rst_paddr", {16'd0, paddr}, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_pstrb", {28'd0, pstrb}, 32'd0);
      chk("rst_hready", {31'd0, hready_o}, 32'd1);
      chk("rst_hresp", {31'd0, hresp_o}, 32'd0);
      chk("rst_hrdata", hrdata_o, 32'd0);
      hresetn = 1'b1;
      step();

      // IDLE and BUSY transfers: zero-wait OKAY, no APB activity
      hsel_i = 1'b1; haddr = 32'h4001_0000; htrans = HTRANS_IDLE;
      step();
      chk("idle_hready", {31'd0, hready_o}, 32'd1);
      chk("idle_hresp", {31'd0, hresp_o}, 32'd0);
      htrans = HTRANS_BUSY;
      step();
      step();
      chk("busy_hready", {31'd0, hready_o}, 32'd1);
      chk("busy_psel", {27'd0, psel}, 32'd0);
      hsel_i = 1'b0; htrans = HTRANS_IDLE;
      step();

      // Read slave 1, minimum latency
      exp_ahb(1'b0, 32'hA5A5_0001, 3);
      exp_apb(16'h0010, 5'b00010, 1'b0, 32'd0, 4'b0000, 1, 1);
      addr_phase(32'h4001_0010, 1'b0, 32'd0, 4'd0);
      wait_done();

      // Write slave 4 with pclken 1-in-2; first SETUP cycle has pclken=0
      exp_ahb(1'b0, 32'hA5A5_0001, 5);
      exp_apb(16'h0008, 5'b10000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 2, 2);
      toggle_en = 1'b1; pclken = 1'b0;
      addr_phase(32'h4004_0008, 1'b1, 32'hDEAD_BEEF, 4'b0011);
      wait_done();
      toggle_en = 1'b0; pclken = 1'b1;

      // Unmapped window 7: ERROR without APB cycle
      exp_ahb(1'b1, 32'hA5A5_0001, 1);
      addr_phase(32'h4007_0000, 1'b0, 32'd0, 4'd0);
      wait_done();

      // PSLVERR on slave 2 write, issued back-to-back from ERR2
      pslverr_i = 5'b00100;
      exp_ahb(1'b1, 32'hA5A5_0001, 4);
      exp_apb(16'h0004, 5'b00100, 1'b1, 32'h1234_5678, 4'b1111, 1, 1);
      addr_phase(32'h4002_0004, 1'b1, 32'h1234_5678, 4'b1111);
      wait_done();
      pslverr_i = 5'b00000;

      // Timeout on slave 0 after 4 ACCESS cycles, then a read accepted in ERR2
      pready_i = 5'b11110;
      exp_ahb(1'b1, 32'hA5A5_0001, 7);
      exp_apb(16'h0020, 5'b00001, 1'b0, 32'd0, 4'b0000, 1, 4);
      addr_phase(32'h4000_0020, 1'b0, 32'd0, 4'd0);
      wait_done();
      exp_ahb(1'b0, 32'hA5A5_0003, 3);
      exp_apb(16'h0044, 5'b01000, 1'b0, 32'd0, 4'b0000, 1, 1);
      addr_phase(32'h4003_0044, 1'b0, 32'd0, 4'd0);
      wait_done();
      pready_i = 5'b11111;

      // Reset sampled while in ACCESS abandons the transfer
      pready_i = 5'b11101;
      exp_apb(16'h0000, 5'b00010, 1'b0, 32'd0, 4'b0000, 0, 0);
      addr_phase(32'h4001_0000, 1'b0, 32'd0, 4'd0);
      step();
      step();
      chk("pre_reset_penable", {31'd0, penable}, 32'd1);
      hresetn = 1'b0;
      step();
      chk("mid_rst_psel", {27'd0, psel}, 32'd0);
      chk("mid_rst_penable", {31'd0, penable}, 32'd0);
      chk("mid_rst_hready", {31'd0, hready_o}, 32'd1);
      chk("mid_rst_hresp", {31'd0, hresp_o}, 32'd0);
      chk("mid_rst_hrdata", hrdata_o, 32'd0);
      hresetn = 1'b1;
      pready_i = 5'b11111;
      step();

      // Recovery read after reset
      exp_ahb(1'b0, 32'hA5A5_0001, 3);
      exp_apb(16'h0010, 5'b00010, 1'b0, 32'd0, 4'b0000, 1, 1);
      addr_phase(32'h4001_0010, 1'b0, 32'd0, 4'd0);
      wait_done();
      repeat (3) step();

      chk("ahb_queue_drained", ahb_q.size(), 32'd0);
      chk("apb_queue_drained", apb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb2apb_bridge_pipe.md
Name: ahb2apb_bridge_pipe

Overview:
Second-generation AHB-Lite to APB bridge with registered address/data capture and a parameterised slave count. Slave decode is a fixed window per slave, and PSLVERR is propagated as a two-cycle AHB ERROR response. Adds an access timeout and a pclken-qualified APB phase advance. It sits between the AHB interconnect slave port and the APB peripheral cluster (UART/SPI/I2C/Memory/LED and further slaves) in the single hclk domain.

Parameters:
HADDR_WIDTH, 32, AHB address width
PADDR_WIDTH, 16, APB address width; each slave window is 2^PADDR_WIDTH bytes
DATA_WIDTH, 32, data width (8/16/32)
PSLV_NUM, 5, number of APB slaves (1..16)
SEL_BITS, 4, haddr bits above PADDR_WIDTH used as slave index
TIMEOUT_CYC, 256, pclken-qualified ACCESS cycles before forced error; 0 disables the timeout

Ports:
- Clocking: one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
hclk  in  1  bridge clock (single clock domain)
hresetn  in  1  synchronous active-low reset
hsel_i  in  1  AHB slave select
haddr  in  HADDR_WIDTH  AHB address
htrans  in  2  AHB transfer type
hwrite  in  1  AHB write
hsize  in  3  AHB size (captured only; no checking)
hwdata  in  DATA_WIDTH  AHB write data (data phase)
hwstrb  in  DATA_WIDTH/8  AHB write strobes (data phase)
hready_i  in  1  AHB bus ready
hready_o  out  1  bridge ready
hresp_o  out  1  0=OKAY, 1=ERROR
hrdata_o  out  DATA_WIDTH  read data
pclken  in  1  APB clock enable
paddr  out  PADDR_WIDTH  APB address (registered)
psel  out  PSLV_NUM  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB write
pwdata  out  DATA_WIDTH  APB write data (registered)
pstrb  out  DATA_WIDTH/8  APB strobes (write only; 0 on reads)
pready_i  in  PSLV_NUM  per-slave ready
pslverr_i  in  PSLV_NUM  per-slave error
prdata_i  in  PSLV_NUM*DATA_WIDTH  slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset values: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, hready_o=1, hresp_o=0, hrdata_o=0. Reset mid-transfer abandons the APB access immediately; there is no completion.
- Accept condition: hsel_i & htrans[1] & hready_i in a cycle where hready_o=1. On accept: latch paddr, hwrite, and slave index idx=haddr[PADDR_WIDTH +: SEL_BITS].
- IDLE/BUSY transfers and non-selected cycles get a zero-wait OKAY response.
- States: IDLE, PEND, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE: accept -> PEND if idx<PSLV_NUM; otherwise -> ERR1 (unmapped address, no APB cycle).
- PEND: one cycle, hready_o=0. Latch hwdata/hwstrb for writes (pstrb=0 for reads). -> SETUP.
- SETUP: psel[idx]=1, penable=0, hready_o=0. Advance to ACCESS only in a cycle with pclken=1.
- ACCESS: psel[idx]=1, penable=1, hready_o=0. Completion is evaluated only when pclken=1:
  - pready_i[idx]=1 and pslverr_i[idx]=1 -> ERR1
  - pready_i[idx]=1 and pslverr_i[idx]=0 -> DONE; capture prdata slice idx into hrdata_o if read
  - otherwise increment the timeout counter; when it reaches TIMEOUT_CYC -> ERR1
- ACCESS exit: psel and penable drop to 0 in the cycle after completion. The counter clears on ACCESS entry.
- DONE: hready_o=1, hresp_o=0. A new accept here -> PEND/ERR1 (back-to-back pipelining); otherwise -> IDLE.
- ERR1: hready_o=0, hresp_o=1. -> ERR2.
- ERR2: hready_o=1, hresp_o=1. Accept is allowed (same rules as DONE); otherwise -> IDLE.
- hrdata_o holds its last read value until the next successful read. Write completions do not alter it.
- Minimum latency with pclken=1 and pready=1: address in cycle 0; hready_o low in cycles 1-3; hready_o high in cycle 4 with data.
- Timing: all outputs are registered except hready_o/hresp_o, which are decoded from the state register (glitch-free, no input combinational path).

Decomposition:
- Package ahb_apb_pkg holds:
  - bridge_state_t enum (7 states)
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HRESP_OKAY/ERROR constants
- Sub-module apb_slave_decode: combinational idx extraction, in-range flag, and one-hot generation. Reused by future bridges.
- The FSM, data latches and timeout counter stay in the top module.

Test Plan:
- Read slave 1, haddr=0x4001_0010, pclken=1, pready_i[1]=1 at first ACCESS, prdata=0xA5A5_0001 -> paddr=0x0010, psel=5'b00010, hready_o low 3 cycles, then hready_o=1 with hrdata_o=0xA5A5_0001, hresp_o=0.
- Write slave 4, haddr=0x4004_0008, hwdata=0xDEAD_BEEF, hwstrb=4'b0011, pclken toggling 1-in-2 -> SETUP held until pclken=1; pwdata=0xDEAD_BEEF and pstrb=4'b0011 throughout SETUP/ACCESS; single DONE cycle.
- Unmapped haddr=0x4007_0000 (PSLV_NUM=5) -> psel stays 0; ERR1 (hready_o=0, hresp_o=1) then ERR2 (hready_o=1, hresp_o=1).
- PSLVERR on slave 2 write -> two-cycle ERROR response; hrdata_o unchanged from prior read.
- Timeout: TIMEOUT_CYC=4, pready_i[0]=0 forever, pclken=1 -> after 4 ACCESS cycles psel drops and a two-cycle ERROR follows; then a back-to-back NONSEQ read accepted in ERR2 completes OKAY.
- Reset: hresetn=0 sampled while in ACCESS -> next cycle psel=0, penable=0, hready_o=1, hrdata_o=0.
